debouncer: RTL and testbench

DEBOUNCER -- requirements
Module: debouncer

---
 rtl/debouncer.sv | 51 +++++
 tb/tb_debouncer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Switch debouncer: the output follows the sampled input only after 2^N_BOUNCE
// consecutive differing edges. Define DEBOUNCER_SYNC_EN to add a two-flop input synchronizer.
module debouncer #(
  parameter int unsigned N_BOUNCE = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sig,
  output logic o_sig_debounced
);

  localparam logic [N_BOUNCE-1:0] CNT_MAX = '1;

  logic                s;
  logic [N_BOUNCE-1:0] cnt;

`ifdef DEBOUNCER_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_sig;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = i_sig;
`endif

  // Terminal count wins over increment, so cnt never wraps and the output flips on the 2^N-th differing edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt             <= '0;
      o_sig_debounced <= 1'b0;
    end else if (s == o_sig_debounced) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt             <= '0;
      o_sig_debounced <= s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (N_BOUNCE=4): directed scenarios plus random bursts
// against a window-history reference model. Works with or without DEBOUNCER_SYNC_EN.
module tb_debouncer;

  localparam int unsigned NB  = 4;
  localparam int unsigned WIN = 1 << NB;
`ifdef DEBOUNCER_SYNC_EN
  localparam int unsigned PIPE = 2;
`else
  localparam int unsigned PIPE = 0;
`endif
  // Edges from the first sample of a new level to the edge that changes the output.
  localparam int unsigned LAT = WIN + PIPE - 1;

  logic clk = 1'b0;
  logic rstn;
  logic i_sig;
  logic o_sig_debounced;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: input delay line, history of s since the last output change.
  bit pipe_q[$];
  bit hist_q[$];
  bit m_out;

  debouncer #(.N_BOUNCE(NB)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_sig          (i_sig),
    .o_sig_debounced(o_sig_debounced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < int'(PIPE); i++) pipe_q.push_back(1'b0);
    hist_q.delete();
    m_out = 1'b0;
  endtask

  // Output flips when the last WIN sampled values since the previous flip all differ from it.
  task automatic model_edge(input bit v);
    bit s;
    bit all_diff;
    if (PIPE == 0) s = v;
    else begin
      s = pipe_q.pop_front();
      pipe_q.push_back(v);
    end
    hist_q.push_back(s);
    if (hist_q.size() > WIN) void'(hist_q.pop_front());
    if (hist_q.size() == WIN) begin
      all_diff = 1'b1;
      foreach (hist_q[i]) if (hist_q[i] == m_out) all_diff = 1'b0;
      if (all_diff) begin
        m_out = ~m_out;
        hist_q.delete();
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input bit v, input string tag);
    i_sig = v;
    @(posedge clk);
    if (rstn) model_edge(v);
    @(negedge clk);
    check(tag, o_sig_debounced, m_out);
  endtask

  task automatic hold_until(input bit v, input bit target, input string tag, output int n);
    n = 0;
    do begin
      cycle(v, tag);
      n++;
    end while (o_sig_debounced !== target && n < 3 * int'(WIN));
  endtask

  task automatic apply_reset(input string tag);
    rstn = 1'b0;
    model_reset();
    #1;
    check(tag, o_sig_debounced, 0);
  endtask

  initial begin
    int n;
    rstn  = 1'b0;
    i_sig = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held with a toggling input keeps the output low.
    for (int i = 0; i < 10; i++) cycle(bit'(i % 2 == 0), "rst_hold");
    rstn = 1'b1;

    // Toggle 10 cycles ending low, then hold high.
    for (int i = 0; i < 10; i++) cycle(bit'(i % 2 == 0), "toggle_up");
    hold_until(1'b1, 1'b1, "rise", n);
    check("rise_latency", n, LAT + 1);
    for (int i = 0; i < 30; i++) cycle(1'b1, "stay_high");
    check("stay_high_end", o_sig_debounced, 1);

    // Symmetric fall.
    for (int i = 0; i < 10; i++) cycle(bit'(i % 2 == 1), "toggle_dn");
    hold_until(1'b0, 1'b0, "fall", n);
    check("fall_latency", n, LAT + 1);
    for (int i = 0; i < 5; i++) cycle(1'b0, "stay_low");

    // A one-cycle glitch discards a partial count.
    for (int i = 0; i < 12; i++) cycle(1'b1, "partial");
    check("partial_no_change", o_sig_debounced, 0);
    cycle(1'b0, "glitch");
    hold_until(1'b1, 1'b1, "rerise", n);
    check("rerise_latency", n, LAT + 1);

    // Reset mid-count while high: immediate clear, stays low afterwards.
    for (int i = 0; i < 10 + int'(PIPE); i++) cycle(1'b0, "pre_rst");
    check("pre_rst_high", o_sig_debounced, 1);
    apply_reset("async_clear");
    for (int i = 0; i < 3; i++) cycle(1'b0, "in_rst");
    rstn = 1'b1;
    for (int i = 0; i < 25; i++) cycle(1'b0, "post_rst_low");

    // Release with the input already high: normal latency, no shortcut.
    apply_reset("rst_again");
    cycle(1'b1, "rst_high_in");
    rstn = 1'b1;
    hold_until(1'b1, 1'b1, "startup", n);
    check("startup_latency", n, LAT + 1);

    // Continuous toggling never changes the output.
    for (int i = 0; i < 4 * int'(WIN); i++) cycle(bit'(i % 2), "fast_toggle");
    check("fast_toggle_end", o_sig_debounced, 1);

    // Random bursts: noise, steady holds, toggles, occasional resets.
    for (int b = 0; b < 120; b++) begin
      int unsigned kind;
      int unsigned len;
      bit lvl;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 40);
      lvl  = bit'($urandom_range(0, 1));
      if (kind == 0) begin
        apply_reset("rnd_rst");
        for (int i = 0; i < int'(len % 4); i++) cycle(bit'($urandom_range(0, 1)), "rnd_in_rst");
        rstn = 1'b1;
      end else if (kind < 4) begin
        for (int i = 0; i < int'(len); i++) cycle(bit'($urandom_range(0, 1)), "rnd_noise");
      end else if (kind < 8) begin
        for (int i = 0; i < int'(len); i++) cycle(lvl, "rnd_hold");
      end else begin
        for (int i = 0; i < int'(len); i++) cycle(bit'(i % 2) ^ lvl, "rnd_toggle");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
